// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: SPI mode-0 slave bridging write/read/ID commands onto an internal byte memory.
module spi_mem_bridge #(
  parameter int          ADDR_WIDTH = 17,
  parameter int          ADDR_BYTES = 3,
  parameter logic [7:0]  DEV_ID     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CS,
  input  logic                  SCLK,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  busy,
  output logic                  wr_strobe,
  output logic                  cmd_err,
  output logic [ADDR_WIDTH-1:0] current_addr,
  output logic [7:0]            current_data
);
  localparam int AB_W = $clog2(ADDR_BYTES) + 1;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WRITE, READ, ID, IGNORE} state_t;
  state_t                r_state;
  logic [1:0]            r_cs_s, r_sclk_s, r_mosi_s;
  logic                  r_cs_d, r_sclk_d;
  logic [2:0]            r_bit_cnt;
  logic [AB_W-1:0]       r_abyte;
  logic [7:0]            r_shift, r_tx;
  logic [ADDR_WIDTH-1:0] r_addr, r_cur_addr;
  logic [7:0]            r_cur_data;
  logic                  r_wr_int, r_fetch, r_miso, r_wr_strobe, r_cmd_err;
  logic [7:0]            r_mem [0:2**ADDR_WIDTH-1];
  logic                  w_cs_fall, w_cs_rise, w_rise, w_fall, w_byte_done, w_commit, w_cmd_ok;
  logic [7:0]            w_byte;
  logic [ADDR_WIDTH+7:0] w_addr_sh;
  assign w_cs_fall   = r_cs_d & ~r_cs_s[1];
  assign w_cs_rise   = ~r_cs_d & r_cs_s[1];
  assign w_rise      = r_sclk_s[1] & ~r_sclk_d;
  assign w_fall      = ~r_sclk_s[1] & r_sclk_d;
  assign w_byte      = {r_shift[6:0], r_mosi_s[1]};
  assign w_byte_done = w_rise & (r_bit_cnt == 3'd7);
  assign w_commit    = w_byte_done & (r_state == WRITE);
  assign w_cmd_ok    = w_byte inside {8'h02, 8'h03, 8'h9F};
  assign w_addr_sh   = {r_addr, w_byte};
  assign MISO         = r_miso & ~CS;
  assign busy         = r_state != IDLE;
  assign wr_strobe    = r_wr_strobe;
  assign cmd_err      = r_cmd_err;
  assign current_addr = r_cur_addr;
  assign current_data = r_cur_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cs_s   <= '0;
      r_sclk_s <= '0;
      r_mosi_s <= '0;
      r_cs_d   <= 1'b0;
      r_sclk_d <= 1'b0;
    end else begin
      r_cs_s   <= {r_cs_s[0], CS};
      r_sclk_s <= {r_sclk_s[0], SCLK};
      r_mosi_s <= {r_mosi_s[0], MOSI};
      r_cs_d   <= r_cs_s[1];
      r_sclk_d <= r_sclk_s[1];
    end
  always_ff @(posedge clk)
    if (w_commit) r_mem[r_addr] <= w_byte;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_abyte     <= '0;
      r_shift     <= '0;
      r_tx        <= '0;
      r_addr      <= '0;
      r_cur_addr  <= '0;
      r_cur_data  <= '0;
      r_wr_int    <= 1'b0;
      r_fetch     <= 1'b0;
      r_miso      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_fetch     <= 1'b0;
      if (w_rise) begin
        r_shift   <= w_byte;
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_fall) begin
        r_miso <= (r_state == READ || r_state == ID) ? r_tx[7] : 1'b0;
        r_tx   <= {r_tx[6:0], 1'b0};
      end
      // fetch runs one clk after the address register settles
      if (r_fetch) begin
        r_tx       <= r_mem[r_addr];
        r_cur_addr <= r_addr;
        r_cur_data <= r_mem[r_addr];
      end
      case (r_state)
        IDLE: if (w_cs_fall) begin
          r_state   <= CMD;
          r_bit_cnt <= '0;
          r_abyte   <= '0;
        end
        CMD: if (w_byte_done) begin
          r_wr_int  <= w_byte == 8'h02;
          r_state   <= (w_byte == 8'h02 || w_byte == 8'h03) ? ADDR : (w_byte == 8'h9F) ? ID : IGNORE;
          r_cmd_err <= r_cmd_err | ~w_cmd_ok;
          r_tx      <= DEV_ID;
        end
        ADDR: if (w_byte_done) begin
          r_addr  <= w_addr_sh[ADDR_WIDTH-1:0];
          r_abyte <= r_abyte + AB_W'(1);
          if (r_abyte == AB_W'(ADDR_BYTES - 1)) begin
            r_state <= r_wr_int ? WRITE : READ;
            r_fetch <= ~r_wr_int;
          end
        end
        WRITE: if (w_byte_done) begin
          r_wr_strobe <= 1'b1;
          r_addr      <= r_addr + ADDR_WIDTH'(1);
          r_cur_addr  <= r_addr;
          r_cur_data  <= w_byte;
        end
        READ: if (w_byte_done) begin
          r_addr  <= r_addr + ADDR_WIDTH'(1);
          r_fetch <= 1'b1;
        end
        ID: if (w_byte_done) r_tx <= DEV_ID;
        default: ;
      endcase
      // a byte completing in the same clk as CS rising is still handled above
      if (w_cs_rise && r_state != IDLE) begin
        r_state <= IDLE;
        r_miso  <= 1'b0;
      end
    end
endmodule
